// File: rtl/gate_op_scheduler.sv
// gate_op_scheduler: round-robin arbiter sharing one decoder-based AND/OR/NOT gate among NREQ requesters.
// Define GATE_SCHED_XOR_EN to make opcode 11 an XOR instead of an illegal-op error.
module gate_op_scheduler #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   a,
    input  logic [NREQ-1:0]   b,
    input  logic [2*NREQ-1:0] op,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_y,
    output logic              rsp_err,
    output logic [15:0]       done_cnt
);
    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, sel_q, sel_d, rsp_id_q, rsp_id_d, pick;
    logic [IDW:0]    idx, nxt;
    logic            a_q, a_d, b_q, b_d, found, y, y11, err11;
    logic [1:0]      op_q, op_d;
    logic [3:0]      d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d, rsp_valid_q, rsp_valid_d;
    logic            rsp_y_q, rsp_y_d, rsp_err_q, rsp_err_d;
    logic [15:0]     done_cnt_q, done_cnt_d;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        gnt_d      = '0;
        rsp_id_d   = rsp_id_q;
        rsp_y_d    = rsp_y_q;
        rsp_err_d  = rsp_err_q;
        done_cnt_d = done_cnt_q;
        found      = 1'b0;
        pick       = '0;
        idx        = '0;
        // first set request at or after ptr, wrapping mod NREQ
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
        nxt = {1'b0, sel_q} + (IDW+1)'(1);
        d   = {a_q & b_q, a_q & ~b_q, ~a_q & b_q, ~a_q & ~b_q};
`ifdef GATE_SCHED_XOR_EN
        y11   = d[1] | d[2];
        err11 = 1'b0;
`else
        y11   = 1'b0;
        err11 = 1'b1;
`endif
        y = op_q == 2'b00 ? d[3] :
            op_q == 2'b01 ? |d[3:1] :
            op_q == 2'b10 ? d[0] | d[1] : y11;
        unique case (state_q)
            IDLE: if (found) begin
                sel_d       = pick;
                a_d         = a[pick];
                b_d         = b[pick];
                op_d        = op[2*pick +: 2];
                gnt_d[pick] = 1'b1;
                state_d     = EVAL;
            end
            EVAL: begin
                rsp_y_d   = y;
                rsp_id_d  = sel_q;
                rsp_err_d = (op_q == 2'b11) & err11;
                ptr_d     = nxt == NREQ_W ? '0 : nxt[IDW-1:0];
                state_d   = RESP;
            end
            RESP: if (rsp_ready) begin
                done_cnt_d = done_cnt_q + 16'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d      = state_d != IDLE;
        rsp_valid_d = state_d == RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            op_q        <= 2'b00;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign done_cnt  = done_cnt_q;
endmodule
